// File: rtl/atm_session_engine_if.sv
// Card/keypad/cfg request bus and status response bus of the ATM session engine.
// The front end drives the master side; the engine is the slave.
interface atm_session_engine_if #(
  parameter int ACCT_W    = 12,
  parameter int BAL_W     = 16,
  parameter int NUM_ACCTS = 8
);
  localparam int IDX_W = $clog2(NUM_ACCTS);

  logic              cfg_we;
  logic [IDX_W-1:0]  cfg_idx;
  logic [ACCT_W-1:0] cfg_acct;
  logic [ACCT_W-1:0] cfg_pin;
  logic [BAL_W-1:0]  cfg_bal;
  logic              card_valid;
  logic [ACCT_W-1:0] card_acct;
  logic              pin_valid;
  logic [ACCT_W-1:0] pin;
  logic              op_valid;
  logic [2:0]        op;
  logic [BAL_W-1:0]  amount;
  logic [ACCT_W-1:0] dst_acct;
  logic              busy;
  logic              rsp_valid;
  logic [2:0]        rsp_status;
  logic [BAL_W-1:0]  rsp_balance;
  logic [BAL_W-1:0]  rsp_dst_balance;

  modport master (
    output cfg_we, cfg_idx, cfg_acct, cfg_pin, cfg_bal,
    output card_valid, card_acct, pin_valid, pin,
    output op_valid, op, amount, dst_acct,
    input  busy, rsp_valid, rsp_status, rsp_balance, rsp_dst_balance
  );

  modport slave (
    input  cfg_we, cfg_idx, cfg_acct, cfg_pin, cfg_bal,
    input  card_valid, card_acct, pin_valid, pin,
    input  op_valid, op, amount, dst_acct,
    output busy, rsp_valid, rsp_status, rsp_balance, rsp_dst_balance
  );
endinterface

// File: rtl/atm_session_engine.sv
// Multi-account ATM session engine: sequential table lookup, PIN check with lockout,
// and deposit/withdraw/balance/transfer/exit, one registered status pulse per step.
module atm_session_engine #(
  parameter int ACCT_W    = 12,
  parameter int BAL_W     = 16,
  parameter int NUM_ACCTS = 8,
  parameter int MAX_TRIES = 3,
  parameter int WD_LIMIT  = 1000,
  parameter int TIMEOUT   = 1023
) (
  input logic                clk,
  input logic                rst,
  atm_session_engine_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_ACCTS);
  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  localparam logic [2:0] ST_OK = 3'd0, ST_NO_ACCT = 3'd1, ST_BAD_PIN = 3'd2, ST_LOCKED = 3'd3;
  localparam logic [2:0] ST_INSUFF = 3'd4, ST_LIMIT = 3'd5, ST_BAD_REQ = 3'd6, ST_TIMEOUT = 3'd7;
  localparam logic [2:0] OP_DEP = 3'd0, OP_WD = 3'd1, OP_BAL = 3'd2, OP_XFER = 3'd3, OP_EXIT = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_PIN_WAIT, S_MENU, S_DST_LOOKUP, S_EXEC
  } state_t;

  state_t                            state_q, state_d;
  logic [NUM_ACCTS-1:0][ACCT_W-1:0]  tbl_acct_q, tbl_acct_d;
  logic [NUM_ACCTS-1:0][ACCT_W-1:0]  tbl_pin_q, tbl_pin_d;
  logic [NUM_ACCTS-1:0][BAL_W-1:0]   tbl_bal_q, tbl_bal_d;
  logic [NUM_ACCTS-1:0]              tbl_vld_q, tbl_vld_d;
  logic [NUM_ACCTS-1:0]              tbl_lock_q, tbl_lock_d;
  logic [ACCT_W-1:0]                 card_q, card_d;
  logic [IDX_W-1:0]                  sess_q, sess_d;
  logic [IDX_W-1:0]                  dst_idx_q, dst_idx_d;
  logic [IDX_W-1:0]                  scan_q, scan_d;
  logic [TRY_W-1:0]                  tries_q, tries_d;
  logic [BAL_W-1:0]                  wd_q, wd_d;
  logic [TMO_W-1:0]                  tmo_q, tmo_d;
  logic [2:0]                        op_q, op_d;
  logic [BAL_W-1:0]                  amt_q, amt_d;
  logic [ACCT_W-1:0]                 dst_acct_q, dst_acct_d;
  logic                              rsp_valid_q, rsp_valid_d;
  logic [2:0]                        rsp_status_q, rsp_status_d;
  logic [BAL_W-1:0]                  rsp_bal_q, rsp_bal_d;
  logic [BAL_W-1:0]                  rsp_dbal_q, rsp_dbal_d;

  // Shared scan datapath for card lookup and transfer destination lookup.
  logic [ACCT_W-1:0] scan_key;
  logic              scan_hit, scan_last;
  logic [BAL_W-1:0]  sess_bal, dst_bal, diff;
  logic [BAL_W:0]    dep_sum, xfer_sum, wd_sum;
  logic              insuff, needs_amt;
  logic [TRY_W-1:0]  tries_nxt;
  logic [TMO_W-1:0]  tmo_nxt;
  logic              pulse;
  logic [2:0]        pulse_st;
  logic [BAL_W-1:0]  pulse_bal, pulse_dbal;

  assign scan_key  = (state_q == S_LOOKUP) ? card_q : dst_acct_q;
  assign scan_hit  = tbl_vld_q[scan_q] && (tbl_acct_q[scan_q] == scan_key);
  assign scan_last = (scan_q == IDX_W'(NUM_ACCTS - 1));
  assign sess_bal  = tbl_bal_q[sess_q];
  assign dst_bal   = tbl_bal_q[dst_idx_q];
  assign diff      = sess_bal - amt_q;
  assign dep_sum   = {1'b0, sess_bal} + {1'b0, amt_q};
  assign xfer_sum  = {1'b0, dst_bal} + {1'b0, amt_q};
  assign wd_sum    = {1'b0, wd_q} + {1'b0, amt_q};
  assign insuff    = (amt_q > sess_bal);
  assign needs_amt = (bus.op == OP_DEP) || (bus.op == OP_WD) || (bus.op == OP_XFER);
  assign tries_nxt = tries_q + 1'b1;
  assign tmo_nxt   = tmo_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    tbl_acct_d = tbl_acct_q;
    tbl_pin_d  = tbl_pin_q;
    tbl_bal_d  = tbl_bal_q;
    tbl_vld_d  = tbl_vld_q;
    tbl_lock_d = tbl_lock_q;
    card_d     = card_q;
    sess_d     = sess_q;
    dst_idx_d  = dst_idx_q;
    scan_d     = scan_q;
    tries_d    = tries_q;
    wd_d       = wd_q;
    tmo_d      = '0;
    op_d       = op_q;
    amt_d      = amt_q;
    dst_acct_d = dst_acct_q;
    pulse      = 1'b0;
    pulse_st   = ST_OK;
    pulse_bal  = sess_bal;
    pulse_dbal = '0;

    case (state_q)
      S_IDLE: begin
        if (bus.cfg_we) begin
          tbl_acct_d[bus.cfg_idx] = bus.cfg_acct;
          tbl_pin_d[bus.cfg_idx]  = bus.cfg_pin;
          tbl_bal_d[bus.cfg_idx]  = bus.cfg_bal;
          tbl_vld_d[bus.cfg_idx]  = 1'b1;
          tbl_lock_d[bus.cfg_idx] = 1'b0;
        end else if (bus.card_valid) begin
          card_d  = bus.card_acct;
          tries_d = '0;
          wd_d    = '0;
          scan_d  = '0;
          state_d = S_LOOKUP;
        end
      end

      // A successful lookup also answers with OK so every step yields one pulse.
      S_LOOKUP: begin
        if (scan_hit) begin
          pulse = 1'b1;
          if (tbl_lock_q[scan_q]) begin
            pulse_st  = ST_LOCKED;
            pulse_bal = '0;
            state_d   = S_IDLE;
          end else begin
            sess_d    = scan_q;
            pulse_bal = tbl_bal_q[scan_q];
            state_d   = S_PIN_WAIT;
          end
        end else if (scan_last) begin
          pulse     = 1'b1;
          pulse_st  = ST_NO_ACCT;
          pulse_bal = '0;
          state_d   = S_IDLE;
        end else begin
          scan_d = scan_q + 1'b1;
        end
      end

      S_PIN_WAIT: begin
        if (bus.pin_valid) begin
          pulse = 1'b1;
          if (bus.pin == tbl_pin_q[sess_q]) begin
            state_d = S_MENU;
          end else if (tries_nxt == TRY_W'(MAX_TRIES)) begin
            tries_d            = tries_nxt;
            tbl_lock_d[sess_q] = 1'b1;
            pulse_st           = ST_LOCKED;
            state_d            = S_IDLE;
          end else begin
            tries_d  = tries_nxt;
            pulse_st = ST_BAD_PIN;
          end
        end else if (tmo_nxt == TMO_W'(TIMEOUT)) begin
          pulse    = 1'b1;
          pulse_st = ST_TIMEOUT;
          state_d  = S_IDLE;
        end else begin
          tmo_d = tmo_nxt;
        end
      end

      S_MENU: begin
        if (bus.op_valid) begin
          op_d       = bus.op;
          amt_d      = bus.amount;
          dst_acct_d = bus.dst_acct;
          if (bus.op > OP_EXIT || (needs_amt && bus.amount == '0)) begin
            pulse    = 1'b1;
            pulse_st = ST_BAD_REQ;
          end else begin
            case (bus.op)
              OP_BAL:  pulse = 1'b1;
              OP_EXIT: begin
                pulse   = 1'b1;
                state_d = S_IDLE;
              end
              OP_XFER: begin
                scan_d  = '0;
                state_d = S_DST_LOOKUP;
              end
              default: state_d = S_EXEC;
            endcase
          end
        end else if (tmo_nxt == TMO_W'(TIMEOUT)) begin
          pulse    = 1'b1;
          pulse_st = ST_TIMEOUT;
          state_d  = S_IDLE;
        end else begin
          tmo_d = tmo_nxt;
        end
      end

      S_DST_LOOKUP: begin
        if (scan_hit) begin
          if (scan_q == sess_q) begin
            pulse    = 1'b1;
            pulse_st = ST_BAD_REQ;
            state_d  = S_MENU;
          end else if (tbl_lock_q[scan_q]) begin
            pulse    = 1'b1;
            pulse_st = ST_LOCKED;
            state_d  = S_MENU;
          end else begin
            dst_idx_d = scan_q;
            state_d   = S_EXEC;
          end
        end else if (scan_last) begin
          pulse    = 1'b1;
          pulse_st = ST_NO_ACCT;
          state_d  = S_MENU;
        end else begin
          scan_d = scan_q + 1'b1;
        end
      end

      // Carries and borrows are checked before any write, so the table never sees a wrap.
      S_EXEC: begin
        pulse   = 1'b1;
        state_d = S_MENU;
        case (op_q)
          OP_DEP: begin
            if (dep_sum[BAL_W]) begin
              pulse_st = ST_BAD_REQ;
            end else begin
              tbl_bal_d[sess_q] = dep_sum[BAL_W-1:0];
              pulse_bal         = dep_sum[BAL_W-1:0];
            end
          end
          OP_WD: begin
            if (insuff) begin
              pulse_st = ST_INSUFF;
            end else if (wd_sum > (BAL_W+1)'(WD_LIMIT)) begin
              pulse_st = ST_LIMIT;
            end else begin
              tbl_bal_d[sess_q] = diff;
              wd_d              = wd_sum[BAL_W-1:0];
              pulse_bal         = diff;
            end
          end
          OP_XFER: begin
            if (insuff) begin
              pulse_st = ST_INSUFF;
            end else if (xfer_sum[BAL_W]) begin
              pulse_st = ST_BAD_REQ;
            end else begin
              tbl_bal_d[sess_q]    = diff;
              tbl_bal_d[dst_idx_q] = xfer_sum[BAL_W-1:0];
              pulse_bal            = diff;
              pulse_dbal           = xfer_sum[BAL_W-1:0];
            end
          end
          default: pulse_st = ST_BAD_REQ;
        endcase
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rsp_valid_d  = pulse;
    rsp_status_d = rsp_status_q;
    rsp_bal_d    = rsp_bal_q;
    rsp_dbal_d   = rsp_dbal_q;
    if (pulse) begin
      rsp_status_d = pulse_st;
      rsp_bal_d    = pulse_bal;
      rsp_dbal_d   = pulse_dbal;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      tbl_acct_q   <= '0;
      tbl_pin_q    <= '0;
      tbl_bal_q    <= '0;
      tbl_vld_q    <= '0;
      tbl_lock_q   <= '0;
      card_q       <= '0;
      sess_q       <= '0;
      dst_idx_q    <= '0;
      scan_q       <= '0;
      tries_q      <= '0;
      wd_q         <= '0;
      tmo_q        <= '0;
      op_q         <= '0;
      amt_q        <= '0;
      dst_acct_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_status_q <= '0;
      rsp_bal_q    <= '0;
      rsp_dbal_q   <= '0;
    end else begin
      state_q      <= state_d;
      tbl_acct_q   <= tbl_acct_d;
      tbl_pin_q    <= tbl_pin_d;
      tbl_bal_q    <= tbl_bal_d;
      tbl_vld_q    <= tbl_vld_d;
      tbl_lock_q   <= tbl_lock_d;
      card_q       <= card_d;
      sess_q       <= sess_d;
      dst_idx_q    <= dst_idx_d;
      scan_q       <= scan_d;
      tries_q      <= tries_d;
      wd_q         <= wd_d;
      tmo_q        <= tmo_d;
      op_q         <= op_d;
      amt_q        <= amt_d;
      dst_acct_q   <= dst_acct_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_status_q <= rsp_status_d;
      rsp_bal_q    <= rsp_bal_d;
      rsp_dbal_q   <= rsp_dbal_d;
    end
  end

  assign bus.busy            = (state_q != S_IDLE);
  assign bus.rsp_valid       = rsp_valid_q;
  assign bus.rsp_status      = rsp_status_q;
  assign bus.rsp_balance     = rsp_bal_q;
  assign bus.rsp_dst_balance = rsp_dbal_q;
endmodule

// File: tb/tb_atm_session_engine.sv
// Scoreboard bench for atm_session_engine: directed scenarios plus a random session walk,
// each step's expected response comes from an account-table model and is popped by a monitor.
module tb_atm_session_engine;
  localparam int ACCT_W = 12, BAL_W = 16, NA = 8;
  localparam int MAX_TRIES = 3, WD_LIMIT = 1000, TIMEOUT = 1023;
  localparam int BAL_MAX = (1 << BAL_W) - 1;
  localparam int OK = 0, NO_ACCT = 1, BAD_PIN = 2, LOCKED = 3;
  localparam int INSUFF = 4, LIMIT = 5, BAD_REQ = 6, TMO = 7;

  typedef struct {
    int st;
    bit chk_bal;
    int bal;
    int dbal;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  atm_session_engine_if #(.ACCT_W(ACCT_W), .BAL_W(BAL_W), .NUM_ACCTS(NA)) bus ();

  atm_session_engine #(
    .ACCT_W(ACCT_W), .BAL_W(BAL_W), .NUM_ACCTS(NA),
    .MAX_TRIES(MAX_TRIES), .WD_LIMIT(WD_LIMIT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  exp_t q[$];
  int n_cmp = 0, n_bad = 0;

  // account table and session model
  int m_acct[NA], m_pin[NA], m_bal[NA];
  bit m_vld[NA], m_lock[NA];
  bit s_on, s_menu;
  int s_idx, s_tries, s_wd;

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int find(int a);
    for (int i = 0; i < NA; i++)
      if (m_vld[i] && m_acct[i] == a) return i;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NA; i++) begin
      m_vld[i] = 0; m_lock[i] = 0; m_bal[i] = 0; m_acct[i] = 0; m_pin[i] = 0;
    end
    s_on = 0; s_menu = 0; s_idx = 0; s_tries = 0; s_wd = 0;
  endtask

  task automatic clear_inputs();
    bus.cfg_we = 0; bus.cfg_idx = '0; bus.cfg_acct = '0; bus.cfg_pin = '0; bus.cfg_bal = '0;
    bus.card_valid = 0; bus.card_acct = '0; bus.pin_valid = 0; bus.pin = '0;
    bus.op_valid = 0; bus.op = '0; bus.amount = '0; bus.dst_acct = '0;
  endtask

  // Called at a negedge with inputs already driven; returns negedges until rsp_valid.
  task automatic wait_rsp(string name, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) clear_inputs();
    end while (!bus.rsp_valid && n < 2000);
    if (!bus.rsp_valid) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_no_rsp: got no rsp_valid within %0d cycles, required one pulse", name, n);
    end
    chk({name, "_busy"}, int'(bus.busy), int'(s_on));
  endtask

  task automatic push(int st, bit cb, int bal, int dbal);
    exp_t e;
    e.st = st; e.chk_bal = cb; e.bal = bal; e.dbal = dbal;
    q.push_back(e);
  endtask

  task automatic act_cfg(int idx, int acct, int pin, int bal);
    bus.cfg_we = 1; bus.cfg_idx = idx[2:0]; bus.cfg_acct = acct[ACCT_W-1:0];
    bus.cfg_pin = pin[ACCT_W-1:0]; bus.cfg_bal = bal[BAL_W-1:0];
    m_acct[idx] = acct; m_pin[idx] = pin; m_bal[idx] = bal; m_vld[idx] = 1; m_lock[idx] = 0;
    @(negedge clk);
    clear_inputs();
    chk("cfg_busy", int'(bus.busy), 0);
  endtask

  task automatic act_card(int acct);
    int idx, n;
    idx = find(acct);
    if (idx < 0) push(NO_ACCT, 0, 0, 0);
    else if (m_lock[idx]) push(LOCKED, 0, 0, 0);
    else begin
      push(OK, 1, m_bal[idx], 0);
      s_on = 1; s_menu = 0; s_idx = idx; s_tries = 0; s_wd = 0;
    end
    bus.card_valid = 1; bus.card_acct = acct[ACCT_W-1:0];
    wait_rsp("card", n);
    chk("lookup_cycles", n - 1, (idx < 0) ? NA : idx + 1);
  endtask

  task automatic act_pin(int p);
    int n;
    if (p == m_pin[s_idx]) begin
      s_menu = 1;
      push(OK, 1, m_bal[s_idx], 0);
    end else begin
      s_tries++;
      if (s_tries == MAX_TRIES) begin
        m_lock[s_idx] = 1; s_on = 0;
        push(LOCKED, 1, m_bal[s_idx], 0);
      end else push(BAD_PIN, 1, m_bal[s_idx], 0);
    end
    bus.pin_valid = 1; bus.pin = p[ACCT_W-1:0];
    wait_rsp("pin", n);
  endtask

  task automatic act_op(int op, int amt, int dst);
    int n, st, b, d, dbal;
    b = m_bal[s_idx]; st = OK; dbal = 0;
    if (op > 4 || ((op == 0 || op == 1 || op == 3) && amt == 0)) st = BAD_REQ;
    else if (op == 4) begin s_on = 0; s_menu = 0; end
    else if (op == 0) begin
      if (b + amt > BAL_MAX) st = BAD_REQ; else m_bal[s_idx] = b + amt;
    end else if (op == 1) begin
      if (amt > b) st = INSUFF;
      else if (s_wd + amt > WD_LIMIT) st = LIMIT;
      else begin m_bal[s_idx] = b - amt; s_wd += amt; end
    end else if (op == 3) begin
      d = find(dst);
      if (d < 0) st = NO_ACCT;
      else if (d == s_idx) st = BAD_REQ;
      else if (m_lock[d]) st = LOCKED;
      else if (amt > b) st = INSUFF;
      else if (m_bal[d] + amt > BAL_MAX) st = BAD_REQ;
      else begin m_bal[s_idx] = b - amt; m_bal[d] += amt; dbal = m_bal[d]; end
    end
    push(st, 1, m_bal[s_idx], dbal);
    bus.op_valid = 1; bus.op = op[2:0]; bus.amount = amt[BAL_W-1:0]; bus.dst_acct = dst[ACCT_W-1:0];
    wait_rsp("op", n);
  endtask

  // Monitor: every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.rsp_valid) begin
      if (q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_rsp: got status %0d, required no response", bus.rsp_status);
      end else begin
        e = q.pop_front();
        chk("rsp_status", int'(bus.rsp_status), e.st);
        if (e.chk_bal) chk("rsp_balance", int'(bus.rsp_balance), e.bal);
        chk("rsp_dst_balance", int'(bus.rsp_dst_balance), e.dbal);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, r, a;
    clear_inputs();
    model_reset();
    rst = 1;
    repeat (3) @(negedge clk);
    chk("reset_rsp_valid", int'(bus.rsp_valid), 0);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_status", int'(bus.rsp_status), 0);
    chk("reset_balance", int'(bus.rsp_balance), 0);
    chk("reset_dst_balance", int'(bus.rsp_dst_balance), 0);
    rst = 0;
    @(negedge clk);

    // basic session, absent card, lockout, unlock by rewrite
    act_cfg(2, 'h123, 'h456, 500);
    act_card('h123); act_pin('h456); act_op(2, 0, 0); act_op(4, 0, 0);
    act_card('h999);
    act_card('h123); act_pin(1); act_pin(2); act_pin(3);
    act_card('h123);
    act_cfg(2, 'h123, 'h456, 500);

    // withdraw limits and insufficient funds
    act_card('h123); act_pin('h456);
    act_op(1, 600, 0); act_op(1, 400, 0); act_op(0, 900, 0); act_op(1, 700, 0);
    act_op(4, 0, 0);

    // transfers and malformed requests
    act_cfg(0, 'h200, 1, 65400);
    act_cfg(5, 'h201, 2, 50);
    act_card('h123); act_pin('h456);
    act_op(3, 200, 'h200); act_op(3, 100, 'h201); act_op(3, 10, 'h123);
    act_op(3, 10, 'h777); act_op(1, 0, 0); act_op(6, 5, 0); act_op(0, 65535, 0);

    // idle menu times out
    push(TMO, 1, m_bal[s_idx], 0);
    s_on = 0; s_menu = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.rsp_valid && n < 1100);
    chk("timeout_cycles", n, TIMEOUT);
    chk("timeout_busy", int'(bus.busy), 0);

    // reset while EXEC is pending: no pulse, table wiped
    act_card('h123); act_pin('h456);
    bus.op_valid = 1; bus.op = 3'd0; bus.amount = 16'd5;
    @(negedge clk);
    rst = 1;
    clear_inputs();
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_exec_busy", int'(bus.busy), 0);
    chk("rst_exec_rsp_valid", int'(bus.rsp_valid), 0);
    rst = 0;
    @(negedge clk);
    act_card('h123);

    // cfg write wins over a same-cycle card
    bus.cfg_we = 1; bus.cfg_idx = 3'd3; bus.cfg_acct = 12'h300; bus.cfg_pin = 12'd7; bus.cfg_bal = 16'd42;
    bus.card_valid = 1; bus.card_acct = 12'h300;
    m_acct[3] = 'h300; m_pin[3] = 7; m_bal[3] = 42; m_vld[3] = 1; m_lock[3] = 0;
    @(negedge clk);
    clear_inputs();
    repeat (3) begin
      chk("cfg_card_busy", int'(bus.busy), 0);
      @(negedge clk);
    end
    act_card('h300); act_pin(7); act_op(4, 0, 0);

    // random walk over a small account pool
    for (int it = 0; it < 250; it++) begin
      a = 'h300 + int'($urandom_range(0, 5));
      if (!s_on) begin
        r = int'($urandom_range(0, 3));
        if (r == 0)
          act_cfg(int'($urandom_range(0, NA - 1)), a, int'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) == 0) ? BAL_MAX - int'($urandom_range(0, 300))
                                              : int'($urandom_range(0, 3000)));
        else act_card(a);
      end else if (!s_menu) begin
        act_pin(($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : m_pin[s_idx]);
      end else begin
        r = int'($urandom_range(0, 9));
        act_op((r > 7) ? 1 : r, ($urandom_range(0, 6) == 0) ? 0 : int'($urandom_range(1, 700)), a);
      end
    end

    repeat (5) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/atm_session_engine.md
Name: atm_session_engine

Overview:
Parameterised clocked successor to the single-account ATM controller. It holds an on-chip table of NUM_ACCTS accounts, each with an account number, PIN, balance and lock flag. It runs one card session at a time: sequential account lookup, PIN check with retry lockout, then deposit, withdraw, balance, transfer or exit. Every step returns exactly one status pulse. It sits between the card/keypad front end and the host, which loads the table through the cfg port.

Parameters:
ACCT_W, 12, width of account number and PIN
BAL_W, 16, width of balance and amounts
NUM_ACCTS, 8, table entries (≥2); IDX_W = $clog2(NUM_ACCTS)
MAX_TRIES, 3, wrong PINs before the account locks
WD_LIMIT, 1000, maximum total withdrawn per session
TIMEOUT, 1023, idle cycles in PIN_WAIT or MENU before the session aborts

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
cfg_we  in  1  write table entry; accepted only in IDLE, ignored otherwise
cfg_idx  in  IDX_W  entry index
cfg_acct  in  ACCT_W  account number
cfg_pin  in  ACCT_W  PIN
cfg_bal  in  BAL_W  balance; a write also clears the entry's lock flag and valid-marks the entry
card_valid  in  1  card inserted; sampled only in IDLE
card_acct  in  ACCT_W  card account number
pin_valid  in  1  PIN entered; sampled only in PIN_WAIT
pin  in  ACCT_W  entered PIN
op_valid  in  1  operation request; sampled only in MENU
op  in  3  0 DEPOSIT, 1 WITHDRAW, 2 BALANCE, 3 TRANSFER, 4 EXIT
amount  in  BAL_W  operation amount
dst_acct  in  ACCT_W  transfer destination
busy  out  1  high in any state other than IDLE
rsp_valid  out  1  one-cycle status pulse
rsp_status  out  3  0 OK, 1 NO_ACCT, 2 BAD_PIN, 3 LOCKED, 4 INSUFF, 5 LIMIT, 6 BAD_REQ, 7 TIMEOUT
rsp_balance  out  BAL_W  session account balance after the step
rsp_dst_balance  out  BAL_W  destination balance; valid on a successful transfer, 0 otherwise

Behaviour:
- Reset:
  - state IDLE; table valid bits, lock flags and balances cleared.
  - tries, session withdrawal total and timeout counter cleared.
  - all outputs 0.
- Outputs are registered. rsp_valid is high for exactly one cycle per step. rsp_* hold their values between pulses.
- States: IDLE, LOOKUP, PIN_WAIT, MENU, DST_LOOKUP, EXEC.
- IDLE:
  - On card_valid, latch card_acct, clear tries and session total, go to LOOKUP.
  - cfg_we has priority over card_valid in the same cycle; card_valid is then ignored.
- LOOKUP: scans one entry per cycle from index 0, first match wins, NUM_ACCTS cycles worst case.
  - Match on an unlocked entry → PIN_WAIT.
  - Match on a locked entry → LOCKED, go to IDLE.
  - No match after the last index → NO_ACCT, go to IDLE.
- PIN_WAIT, on pin_valid:
  - Correct PIN → OK, go to MENU.
  - Wrong PIN → increment tries. If tries == MAX_TRIES, set the lock flag, respond LOCKED, go to IDLE. Otherwise respond BAD_PIN and stay.
- MENU, on op_valid (latch op, amount and dst_acct):
  - DEPOSIT, WITHDRAW or TRANSFER with amount == 0 → BAD_REQ.
  - op > 4 → BAD_REQ.
  - BALANCE → OK with current balance.
  - EXIT → OK, go to IDLE.
  - DEPOSIT or WITHDRAW → EXEC.
  - TRANSFER → DST_LOOKUP.
- DST_LOOKUP: same sequential scan as LOOKUP.
  - Not found → NO_ACCT.
  - Destination is the session account → BAD_REQ.
  - Locked destination → LOCKED.
  - Valid destination → EXEC.
  - Every failure returns to MENU.
- EXEC: one cycle, then MENU. Arithmetic is BAL_W wide and unsigned; a carry or borrow is never written back.
  - DEPOSIT: if balance + amount overflows BAL_W → BAD_REQ. Otherwise write back the sum, OK.
  - WITHDRAW: if amount > balance → INSUFF. Else if session total + amount > WD_LIMIT → LIMIT. Otherwise debit, add to session total, OK.
  - TRANSFER: if amount > balance → INSUFF. Else if destination + amount overflows → BAD_REQ. Otherwise debit source and credit destination in the same cycle, OK, with rsp_dst_balance set.
  - Transfers do not count toward WD_LIMIT.
- Timeout: counter counts cycles in PIN_WAIT or MENU with no valid input and is cleared on any accepted input. When it reaches TIMEOUT → TIMEOUT status, go to IDLE.
- Inputs not sampled in the current state are ignored.
- Reset mid-session aborts immediately with no response.
- The table keeps no partial update: EXEC writes are atomic.

Test Plan:
- Load acct 0x123/PIN 0x456/bal 500 at idx 2; card 0x123, PIN 0x456, BALANCE → OK, rsp_balance=500; lookup takes 3 cycles.
- Card 0x999 (absent) → NO_ACCT after 8 scan cycles. Three wrong PINs on 0x123 → BAD_PIN, BAD_PIN, LOCKED. Next card 0x123 → LOCKED. A cfg rewrite unlocks the account.
- Balance 500: WITHDRAW 600 → INSUFF; WITHDRAW 400 → OK/100; deposit 900 → 1000; WITHDRAW 700 → LIMIT, balance unchanged 1000.
- Transfer 200 from 0x123 (1000) to 0x200 (65400) → BAD_REQ (overflow). Transfer 100 to 0x201 (50) → OK, rsp_balance 900, rsp_dst_balance 150. Transfer to 0x123 → BAD_REQ.
- Enter MENU and hold all valids low for 1023 cycles → TIMEOUT pulse, busy falls. Assert rst during EXEC → IDLE, no rsp_valid.
- cfg_we and card_valid asserted in the same IDLE cycle → write performed, card ignored, busy stays 0.
